// File: rtl/link_control.sv
// link_control
//   Sequences one player-character update per FRAMES_PER_UPDATE video frames:
//   INIT -> IDLE -> REG -> COLL (COLL_WAIT cycles) -> APPLY -> MAP -> LINK -> IDLE.
//   MAP and LINK each give up after TIMEOUT cycles and return to IDLE.
//
// Ports
//   clock, reset           system clock, synchronous active-high reset
//   enable                 game running; no new update starts while low
//   frame_tick             one-cycle pulse per video frame
//   map_done, draw_done    completion from background / character drawers
//   init, idle, reg_action, apply_action, draw_map, draw
//                          one-hot decode of the state register
//   busy                   high in every state except IDLE
//   timeout_err            sticky: MAP or LINK timed out
//   overrun                sticky: frame_tick arrived while busy
//   state_o, frame_div_o   debug view of the state register and frame divider
//
// Handshake: each strobe (draw_map, draw) is a request held high for as long
// as the FSM sits in the matching state; the matching done input is the
// acknowledgement and is sampled only in that state. A done seen at edge N
// drops the request at N. Done levels present outside their state are ignored.
module link_control #(
    parameter int FRAMES_PER_UPDATE = 2,
    parameter int COLL_WAIT         = 2,
    parameter int TIMEOUT           = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic       map_done,
    input  logic       draw_done,
    output logic       init,
    output logic       idle,
    output logic       reg_action,
    output logic       apply_action,
    output logic       draw_map,
    output logic       draw,
    output logic       busy,
    output logic       timeout_err,
    output logic       overrun,
    output logic [2:0] state_o,
    output logic [7:0] frame_div_o
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_REG   = 3'd2,
        S_COLL  = 3'd3,
        S_APPLY = 3'd4,
        S_MAP   = 3'd5,
        S_LINK  = 3'd6
    } state_t;

    localparam logic [7:0]  FDIV_LAST = 8'(FRAMES_PER_UPDATE - 1);
    localparam logic [3:0]  COLL_LAST = 4'(COLL_WAIT - 1);
    localparam logic [16:0] WAIT_LAST = 17'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  frame_div_q, frame_div_d;
    logic [3:0]  coll_cnt_q, coll_cnt_d;
    logic [16:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic        overrun_q, overrun_d;

    logic        update_start;
    logic        timeout_hit;

    // A tick only counts when idle and enabled; ticks in any busy state are dropped.
    assign update_start = (state_q == S_IDLE) && frame_tick && enable
                          && (frame_div_q == FDIV_LAST);

    // Done wins over timeout when both land on the same edge.
    assign timeout_hit = (wait_cnt_q == WAIT_LAST)
                         && (((state_q == S_MAP) && !map_done)
                          || ((state_q == S_LINK) && !draw_done));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  state_d = S_IDLE;
            S_IDLE:  if (update_start) state_d = S_REG;
            S_REG:   state_d = S_COLL;
            S_COLL:  if (coll_cnt_q == COLL_LAST) state_d = S_APPLY;
            S_APPLY: state_d = S_MAP;
            S_MAP: begin
                if (map_done)         state_d = S_LINK;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_LINK: begin
                if (draw_done)        state_d = S_IDLE;
                else if (timeout_hit) state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    // Output decode. COLL keeps reg_action asserted so that exactly one strobe
    // is high in every state; the command latch simply reloads the same command
    // while the collision detector settles.
    always_comb begin
        init         = 1'b0;
        idle         = 1'b0;
        reg_action   = 1'b0;
        apply_action = 1'b0;
        draw_map     = 1'b0;
        draw         = 1'b0;
        case (state_q)
            S_INIT:  init         = 1'b1;
            S_IDLE:  idle         = 1'b1;
            S_REG:   reg_action   = 1'b1;
            S_COLL:  reg_action   = 1'b1;
            S_APPLY: apply_action = 1'b1;
            S_MAP:   draw_map     = 1'b1;
            S_LINK:  draw         = 1'b1;
            default: init         = 1'b1;
        endcase
        busy        = (state_q != S_IDLE);
        timeout_err = timeout_err_q;
        overrun     = overrun_q;
        state_o     = state_q;
        frame_div_o = frame_div_q;
    end

    // Counters and sticky flags
    always_comb begin
        frame_div_d   = frame_div_q;
        coll_cnt_d    = 4'd0;
        wait_cnt_d    = 17'd0;
        timeout_err_d = timeout_err_q | timeout_hit;
        overrun_d     = overrun_q;

        if ((state_q == S_IDLE) && frame_tick && enable) begin
            frame_div_d = (frame_div_q == FDIV_LAST) ? 8'd0 : frame_div_q + 8'd1;
        end

        if (frame_tick && (state_q != S_IDLE) && (state_q != S_INIT)) begin
            overrun_d = 1'b1;
        end

        if ((state_q == S_COLL) && (state_d == S_COLL)) begin
            coll_cnt_d = coll_cnt_q + 4'd1;
        end

        // wait_cnt restarts on every state change, so it is zero on entry to MAP and LINK.
        if (((state_q == S_MAP) || (state_q == S_LINK)) && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + 17'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_div_q   <= 8'd0;
            coll_cnt_q    <= 4'd0;
            wait_cnt_q    <= 17'd0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            frame_div_q   <= frame_div_d;
            coll_cnt_q    <= coll_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

endmodule

// File: tb/tb_link_control.sv
module tb_link_control;

    localparam int FPU = 2;
    localparam int CW  = 2;
    localparam int TO  = 300;

    // one-hot order: {init, idle, reg_action, apply_action, draw_map, draw}
    localparam logic [5:0] O_INIT  = 6'b100000;
    localparam logic [5:0] O_IDLE  = 6'b010000;
    localparam logic [5:0] O_REG   = 6'b001000;
    localparam logic [5:0] O_APPLY = 6'b000100;
    localparam logic [5:0] O_MAP   = 6'b000010;
    localparam logic [5:0] O_LINK  = 6'b000001;

    logic clock = 1'b0;
    logic reset, enable, frame_tick, map_done, draw_done;
    logic init, idle, reg_action, apply_action, draw_map, draw;
    logic busy, timeout_err, overrun;
    logic [2:0] state_o;
    logic [7:0] frame_div_o;

    int n_vec = 0;
    int n_bad = 0;

    link_control #(
        .FRAMES_PER_UPDATE(FPU),
        .COLL_WAIT(CW),
        .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .frame_tick(frame_tick),
        .map_done(map_done), .draw_done(draw_done),
        .init(init), .idle(idle), .reg_action(reg_action), .apply_action(apply_action),
        .draw_map(draw_map), .draw(draw), .busy(busy),
        .timeout_err(timeout_err), .overrun(overrun),
        .state_o(state_o), .frame_div_o(frame_div_o)
    );

    // clock
    always #5 clock = ~clock;

    typedef struct {
        logic       rst, en, tick, md, dd;
        logic [5:0] outs;
        logic       busy, terr, ovr;
        logic [7:0] fdiv;
    } vec_t;

    vec_t vt[33];

    function automatic vec_t mk(logic rst, logic en, logic tick, logic md, logic dd,
                                logic [5:0] outs, logic b, logic terr, logic ovr,
                                logic [7:0] fdiv);
        vec_t v;
        v.rst = rst; v.en = en; v.tick = tick; v.md = md; v.dd = dd;
        v.outs = outs; v.busy = b; v.terr = terr; v.ovr = ovr; v.fdiv = fdiv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // drive one cycle of inputs, then sample just after the edge
    task automatic step(input logic r, input logic e, input logic t, input logic m, input logic d);
        reset = r; enable = e; frame_tick = t; map_done = m; draw_done = d;
        @(posedge clock);
        #1;
    endtask

    // tick until reg_action, then walk COLL and APPLY into MAP with latency checks
    task automatic start_to_map();
        int g = 0;
        while (!reg_action && g < 4) begin
            step(0, 1, 1, 0, 0);
            g++;
        end
        chk("seq_reg", {31'd0, reg_action}, 32'd1);
        step(0, 1, 0, 0, 0);
        chk("seq_coll1", {26'd0, init, idle, reg_action, apply_action, draw_map, draw}, {26'd0, O_REG});
        step(0, 1, 0, 0, 0);
        chk("seq_coll2", {26'd0, init, idle, reg_action, apply_action, draw_map, draw}, {26'd0, O_REG});
        step(0, 1, 0, 0, 0);
        chk("seq_apply", {26'd0, init, idle, reg_action, apply_action, draw_map, draw}, {26'd0, O_APPLY});
        step(0, 1, 0, 0, 0);
        chk("seq_map", {26'd0, init, idle, reg_action, apply_action, draw_map, draw}, {26'd0, O_MAP});
    endtask

    // dly = cycle (counted from MAP entry) on which map_done is driven; 0 = never
    task automatic run_map(input int dly, output int cnt);
        int g = 0;
        cnt = 0;
        while (draw_map && g < 1000) begin
            cnt++;
            step(0, 1, 0, (cnt == dly), 0);
            g++;
        end
    endtask

    task automatic run_link(input int dly, output int cnt);
        int g = 0;
        cnt = 0;
        while (draw && g < 1000) begin
            cnt++;
            step(0, 1, 0, 0, (cnt == dly));
            g++;
        end
    endtask

    initial begin
        int c;
        reset = 1'b1; enable = 1'b0; frame_tick = 1'b0; map_done = 1'b0; draw_done = 1'b0;

        //            rst en tk md dd  outs     busy terr ovr fdiv
        vt[0]  = mk(1, 1, 0, 0, 0, O_INIT,  1, 0, 0, 8'd0);
        vt[1]  = mk(0, 1, 0, 0, 0, O_IDLE,  0, 0, 0, 8'd0);
        vt[2]  = mk(0, 1, 1, 0, 0, O_IDLE,  0, 0, 0, 8'd1);
        vt[3]  = mk(0, 1, 0, 0, 0, O_IDLE,  0, 0, 0, 8'd1);
        vt[4]  = mk(0, 1, 1, 0, 0, O_REG,   1, 0, 0, 8'd0);
        vt[5]  = mk(0, 1, 0, 0, 0, O_REG,   1, 0, 0, 8'd0);
        vt[6]  = mk(0, 1, 0, 0, 0, O_REG,   1, 0, 0, 8'd0);
        vt[7]  = mk(0, 1, 0, 0, 0, O_APPLY, 1, 0, 0, 8'd0);
        vt[8]  = mk(0, 1, 0, 0, 0, O_MAP,   1, 0, 0, 8'd0);
        vt[9]  = mk(0, 1, 0, 1, 1, O_LINK,  1, 0, 0, 8'd0);
        vt[10] = mk(0, 1, 0, 1, 1, O_IDLE,  0, 0, 0, 8'd0);
        // dones held high: draw_done on IDLE entry ignored, minimum period
        vt[11] = mk(0, 1, 1, 1, 1, O_IDLE,  0, 0, 0, 8'd1);
        vt[12] = mk(0, 1, 1, 1, 1, O_REG,   1, 0, 0, 8'd0);
        vt[13] = mk(0, 1, 0, 1, 1, O_REG,   1, 0, 0, 8'd0);
        vt[14] = mk(0, 1, 0, 1, 1, O_REG,   1, 0, 0, 8'd0);
        vt[15] = mk(0, 1, 0, 1, 1, O_APPLY, 1, 0, 0, 8'd0);
        vt[16] = mk(0, 1, 0, 1, 1, O_MAP,   1, 0, 0, 8'd0);
        vt[17] = mk(0, 1, 0, 1, 1, O_LINK,  1, 0, 0, 8'd0);
        vt[18] = mk(0, 1, 0, 1, 1, O_IDLE,  0, 0, 0, 8'd0);
        // enable drops in COLL; overrun ticks in MAP and LINK
        vt[19] = mk(0, 1, 1, 0, 0, O_IDLE,  0, 0, 0, 8'd1);
        vt[20] = mk(0, 1, 1, 0, 0, O_REG,   1, 0, 0, 8'd0);
        vt[21] = mk(0, 1, 0, 0, 0, O_REG,   1, 0, 0, 8'd0);
        vt[22] = mk(0, 0, 0, 0, 0, O_REG,   1, 0, 0, 8'd0);
        vt[23] = mk(0, 0, 0, 0, 0, O_APPLY, 1, 0, 0, 8'd0);
        vt[24] = mk(0, 0, 0, 0, 0, O_MAP,   1, 0, 0, 8'd0);
        vt[25] = mk(0, 0, 0, 0, 0, O_MAP,   1, 0, 0, 8'd0);
        vt[26] = mk(0, 1, 1, 0, 0, O_MAP,   1, 0, 1, 8'd0);
        vt[27] = mk(0, 0, 0, 1, 0, O_LINK,  1, 0, 1, 8'd0);
        vt[28] = mk(0, 1, 1, 0, 0, O_LINK,  1, 0, 1, 8'd0);
        vt[29] = mk(0, 0, 0, 0, 1, O_IDLE,  0, 0, 1, 8'd0);
        vt[30] = mk(0, 0, 1, 0, 0, O_IDLE,  0, 0, 1, 8'd0);
        vt[31] = mk(0, 0, 1, 0, 0, O_IDLE,  0, 0, 1, 8'd0);
        vt[32] = mk(0, 1, 0, 0, 0, O_IDLE,  0, 0, 1, 8'd0);

        for (int i = 0; i < 33; i++) begin
            step(vt[i].rst, vt[i].en, vt[i].tick, vt[i].md, vt[i].dd);
            chk($sformatf("v%0d_outs", i),
                {26'd0, init, idle, reg_action, apply_action, draw_map, draw}, {26'd0, vt[i].outs});
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].busy});
            chk($sformatf("v%0d_terr", i), {31'd0, timeout_err}, {31'd0, vt[i].terr});
            chk($sformatf("v%0d_ovr", i), {31'd0, overrun}, {31'd0, vt[i].ovr});
            chk($sformatf("v%0d_fdiv", i), {24'd0, frame_div_o}, {24'd0, vt[i].fdiv});
        end

        // long MAP (10) and LINK (256) holds
        start_to_map();
        run_map(10, c);
        chk("long_map_cycles", c, 10);
        chk("long_in_link", {31'd0, draw}, 32'd1);
        run_link(256, c);
        chk("long_link_cycles", c, 256);
        chk("long_idle", {31'd0, idle}, 32'd1);
        chk("long_busy", {31'd0, busy}, 32'd0);

        // map_done on the timeout cycle: done wins
        start_to_map();
        run_map(TO, c);
        chk("edge_map_cycles", c, TO);
        chk("edge_in_link", {31'd0, draw}, 32'd1);
        chk("edge_terr", {31'd0, timeout_err}, 32'd0);
        run_link(1, c);
        chk("edge_link_cycles", c, 1);

        // MAP timeout
        start_to_map();
        run_map(0, c);
        chk("to_map_cycles", c, TO);
        chk("to_map_idle", {31'd0, idle}, 32'd1);
        chk("to_map_terr", {31'd0, timeout_err}, 32'd1);

        // normal sequence afterwards keeps the sticky flag
        start_to_map();
        run_map(1, c);
        chk("after_map_cycles", c, 1);
        run_link(1, c);
        chk("after_link_cycles", c, 1);
        chk("after_terr", {31'd0, timeout_err}, 32'd1);

        // LINK timeout
        start_to_map();
        run_map(1, c);
        run_link(0, c);
        chk("to_link_cycles", c, TO);
        chk("to_link_idle", {31'd0, idle}, 32'd1);

        // reset while in MAP with both flags set
        start_to_map();
        chk("pre_rst_terr", {31'd0, timeout_err}, 32'd1);
        chk("pre_rst_ovr", {31'd0, overrun}, 32'd1);
        step(1, 1, 0, 0, 0);
        chk("rst_outs", {26'd0, init, idle, reg_action, apply_action, draw_map, draw}, {26'd0, O_INIT});
        chk("rst_terr", {31'd0, timeout_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        step(0, 1, 0, 0, 0);
        chk("rst_then_idle", {26'd0, init, idle, reg_action, apply_action, draw_map, draw}, {26'd0, O_IDLE});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
